// File: rtl/tc_acc_pkg.sv
// Shared tensor-core definitions: default geometry of the accumulator array
// and the mapping from (row, lane) to bit position inside a flattened bus.
package tc_acc_pkg;

    localparam int N_ADT_DEF   = 4;
    localparam int N_STACK_DEF = 4;
    localparam int DW_DATA_DEF = 32;
    localparam int DW_CNT_DEF  = 8;

    // Lowest bit of lane (r, s) when rows of dw_line bits are packed back to back.
    function automatic int lane_lsb(input int r, input int s, input int dw_line, input int dw_data);
        return r * dw_line + s * dw_data;
    endfunction

endpackage

// File: rtl/tc_acc_lane.sv
// One accumulator lane: wrapping adder, running-sum register and the
// result register that holds the completed tile value for this lane.
module tc_acc_lane
    import tc_acc_pkg::*;
#(
    parameter int DW_DATA = DW_DATA_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      take,
    input  logic                      first,
    input  logic                      done,
    input  logic signed [DW_DATA-1:0] operand,
    output logic signed [DW_DATA-1:0] result
);

    logic signed [DW_DATA-1:0] acc;
    logic signed [DW_DATA-1:0] sum;

    // Two's-complement add that simply drops the carry out of the lane.
    function automatic logic signed [DW_DATA-1:0] add_wrap(
        input logic signed [DW_DATA-1:0] a,
        input logic signed [DW_DATA-1:0] b
    );
        return a + b;
    endfunction

    // An empty accumulator starts from the incoming partial sum, not from stale contents.
    always_comb begin
        sum = first ? operand : add_wrap(acc, operand);
    end

    // Running sum advances on every accepted beat; the result captures it on the closing beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (take) begin
                acc <= sum;
            end
            if (take && done) begin
                result <= sum;
            end
        end
    end

endmodule

// File: rtl/tc_acc.sv
// Tile accumulator: sums partial-sum beats from N_ADT adder trees over the
// K dimension and presents the finished tile with a valid/ready handshake.
// A new tile may close in the same cycle the previous one is consumed.
module tc_acc
    import tc_acc_pkg::*;
#(
    parameter int N_ADT   = N_ADT_DEF,
    parameter int N_STACK = N_STACK_DEF,
    parameter int DW_DATA = DW_DATA_DEF,
    parameter int DW_LINE = N_STACK * DW_DATA,
    parameter int DW_CNT  = DW_CNT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [N_ADT*DW_LINE-1:0] in,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_ADT*DW_LINE-1:0] out,
    output logic [DW_CNT-1:0]        out_nbeats
);

    localparam logic [DW_CNT-1:0] CNT_ONE = {{(DW_CNT-1){1'b0}}, 1'b1};

    logic              first;
    logic [DW_CNT-1:0] cnt;
    logic [DW_CNT-1:0] cnt_next;
    logic              take;
    logic              close;
    logic              handoff;

    // Input is blocked only while a finished tile waits for a consumer.
    assign in_ready = !out_valid | out_ready;
    assign take     = in_valid & in_ready;
    assign close    = take & in_last;
    assign handoff  = out_valid & out_ready;
    assign cnt_next = first ? CNT_ONE : cnt + CNT_ONE;

    // Tile bookkeeping: empty flag, beat count and the output valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first      <= 1'b1;
            cnt        <= '0;
            out_nbeats <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (take) begin
                cnt   <= cnt_next;
                first <= in_last;
                if (in_last) begin
                    out_nbeats <= cnt_next;
                end
            end
            if (close) begin
                out_valid <= 1'b1;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar r = 0; r < N_ADT; r++) begin : g_row
        for (genvar s = 0; s < N_STACK; s++) begin : g_lane
            localparam int LSB = lane_lsb(r, s, DW_LINE, DW_DATA);
            tc_acc_lane #(
                .DW_DATA(DW_DATA)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .take   (take),
                .first  (first),
                .done   (in_last),
                .operand(in[LSB +: DW_DATA]),
                .result (out[LSB +: DW_DATA])
            );
        end
    end

endmodule

// File: tb/tb_tc_acc.sv
// Bench for tc_acc: directed tiles plus randomized traffic, checked every
// cycle against a transaction-level model of tile sums and beat counts.
module tb_tc_acc;

    localparam int NA = 4;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int DL = NS * DW;
    localparam int DC = 8;
    localparam int NL = NA * NS;
    localparam int BW = NA * DL;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_last;
    logic [BW-1:0] in_bus;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_bus;
    logic [DC-1:0] out_nbeats;

    always #5 clk = ~clk;

    tc_acc #(
        .N_ADT  (NA),
        .N_STACK(NS),
        .DW_DATA(DW),
        .DW_LINE(DL),
        .DW_CNT (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in        (in_bus),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_bus),
        .out_nbeats(out_nbeats)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Stimulus lanes, indexed r*NS+s.
    logic [DW-1:0] lanes    [NL];
    // Model: open tile contents and the tile currently presented downstream.
    logic [DW-1:0] tile_sum [NL];
    int            tile_beats;
    logic [DW-1:0] m_res    [NL];
    int            m_nb;
    logic          m_vld;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] exp_out();
        logic [BW-1:0] v;
        v = '0;
        for (int r = 0; r < NA; r++)
            for (int s = 0; s < NS; s++)
                v[r*DL + s*DW +: DW] = m_res[r*NS+s];
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) begin
            tile_sum[i] = '0;
            m_res[i]    = '0;
        end
        tile_beats = 0;
        m_nb       = 0;
        m_vld      = 1'b0;
    endfunction

    task automatic set_all(input logic [DW-1:0] v);
        for (int i = 0; i < NL; i++) lanes[i] = v;
    endtask

    task automatic set_rand();
        for (int i = 0; i < NL; i++) begin
            case ($urandom_range(7))
                0:       lanes[i] = 32'h7FFF_FFFF;
                1:       lanes[i] = 32'h8000_0000;
                2:       lanes[i] = 32'hFFFF_FFFF;
                default: lanes[i] = $urandom;
            endcase
        end
    endtask

    // One clock cycle: drive at negedge, check ready, update model at posedge, check outputs.
    task automatic step(input logic v, input logic l, input logic r, input string tag);
        logic rdy;
        logic hs;
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        for (int rr = 0; rr < NA; rr++)
            for (int ss = 0; ss < NS; ss++)
                in_bus[rr*DL + ss*DW +: DW] = lanes[rr*NS+ss];
        rdy = !m_vld | r;
        hs  = m_vld & r;
        #1;
        chk({tag, ".rdy"}, in_ready, rdy);
        @(posedge clk);
        if (hs) m_vld = 1'b0;
        if (v && rdy) begin
            for (int i = 0; i < NL; i++) tile_sum[i] = tile_sum[i] + lanes[i];
            tile_beats++;
            if (l) begin
                for (int i = 0; i < NL; i++) begin
                    m_res[i]    = tile_sum[i];
                    tile_sum[i] = '0;
                end
                m_nb       = tile_beats % (1 << DC);
                tile_beats = 0;
                m_vld      = 1'b1;
            end
        end
        @(negedge clk);
        chk({tag, ".vld"}, out_valid, m_vld);
        chk({tag, ".out"}, out_bus, exp_out());
        chk({tag, ".nb"}, out_nbeats, m_nb[DC-1:0]);
    endtask

    // Reset pulse with a live beat offered while reset is low; it must be ignored.
    task automatic do_reset(input string tag);
        #2;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        out_ready = 1'b1;
        #1;
        model_clear();
        chk({tag, ".async_vld"}, out_valid, 1'b0);
        chk({tag, ".async_out"}, out_bus, '0);
        chk({tag, ".async_nb"}, out_nbeats, '0);
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, ".rel_vld"}, out_valid, 1'b0);
        chk({tag, ".rel_rdy"}, in_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        in_bus    = '0;
        set_all('0);
        model_clear();
        @(negedge clk);
        do_reset("rst0");

        // Single-beat tile of fives.
        set_all(32'd5);
        step(1, 1, 1, "single");
        step(0, 0, 1, "single_drain");

        // Three beats 1,2,3 with the consumer always ready.
        set_all(32'd1); step(1, 0, 1, "sum3_b1");
        set_all(32'd2); step(1, 0, 1, "sum3_b2");
        set_all(32'd3); step(1, 1, 1, "sum3_b3");
        step(0, 0, 1, "sum3_drop");
        step(0, 0, 1, "sum3_idle");

        // Lane 0 wraps past the positive maximum; other lanes stay zero.
        set_all('0); lanes[0] = 32'h7FFF_FFFF; step(1, 0, 1, "wrap_b1");
        set_all('0); lanes[0] = 32'h0000_0001; step(1, 1, 1, "wrap_b2");
        step(0, 0, 1, "wrap_drain");

        // Stall: tile held for 5 cycles while a last beat is offered, then swap.
        set_all(32'd4); step(1, 1, 0, "stall_fill");
        set_all(32'd7);
        for (int k = 0; k < 5; k++) step(1, 1, 0, "stall_hold");
        step(1, 1, 1, "stall_swap");
        chk("stall_swap_vld", out_valid, 1'b1);
        step(0, 0, 1, "stall_drain");

        // Reset after 2 of 4 beats, then a fresh one-beat tile of nines.
        set_all(32'd3); step(1, 0, 1, "mid_b1");
        step(1, 0, 1, "mid_b2");
        @(negedge clk);
        do_reset("rst_mid");
        set_all(32'd9); step(1, 1, 1, "post_rst");
        step(0, 0, 1, "post_rst_drain");

        // Per-lane distinct values expose any layout or leakage error.
        for (int r = 0; r < NA; r++)
            for (int s = 0; s < NS; s++)
                lanes[r*NS+s] = r*16 + s;
        step(1, 0, 1, "layout_b1");
        step(1, 1, 1, "layout_b2");
        step(0, 0, 1, "layout_drain");

        // Beat counter wraps: 258 beats report as 2.
        set_all(32'd1);
        for (int k = 0; k < 257; k++) step(1, 0, 1, "cntwrap");
        step(1, 1, 1, "cntwrap_last");
        step(0, 0, 1, "cntwrap_drain");

        // Randomized traffic with backpressure and one reset in the middle.
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) begin
                @(negedge clk);
                do_reset("rst_rand");
            end
            set_rand();
            step(($urandom_range(9) < 7), ($urandom_range(3) == 0), ($urandom_range(9) < 6), "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tc_acc.md
TC_ACC -- requirements
Module: tc_acc

Interface
REQ-001 Parameter N_ADT, default 4: number of output rows (one per upstream adder tree).
REQ-002 Parameter N_STACK, default 4: lanes per row.
REQ-003 Parameter DW_DATA, default 32: width of each lane (partial sum and accumulator).
REQ-004 Parameter DW_LINE, default N_STACK*DW_DATA: width of one row.
REQ-005 Parameter DW_CNT, default 8: width of the K-slice beat counter.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  partial-sum beat present.
REQ-009 in_last  input  1  beat is the final K-slice of the current output tile.
REQ-010 in  input  N_ADT*DW_LINE  partial sums; lane (r,s) at bits [(r*DW_LINE + s*DW_DATA) +: DW_DATA].
REQ-011 in_ready  output  1  beat accepted when in_valid and in_ready are both 1.
REQ-012 out_valid  output  1  completed tile held on out.
REQ-013 out_ready  input  1  downstream consumes the tile when out_valid and out_ready are both 1.
REQ-014 out  output  N_ADT*DW_LINE  accumulated tile, same lane layout as in.
REQ-015 out_nbeats  output  DW_CNT  number of beats summed into out.

Function
REQ-016 Lane arithmetic SHALL be two's-complement addition modulo 2^DW_DATA, with no saturation and no flag.
REQ-017 Lanes SHALL be independent; no carry or data crosses lane boundaries.
REQ-018 The block SHALL hold a working accumulator array (acc), a beat counter (cnt), a result array (res), and flag first (1 = acc empty).
REQ-019 in_ready SHALL equal (!out_valid | out_ready) and SHALL be independent of in_valid and in_last.
REQ-020 On an accepted beat with first=1, acc SHALL load in, cnt SHALL load 1, and first SHALL clear.
REQ-021 On an accepted beat with first=0, acc SHALL load acc+in per lane, and cnt SHALL increment, wrapping at 2^DW_CNT.
REQ-022 On an accepted beat with in_last=1, res SHALL load the per-lane sum (or in alone if first=1), out_nbeats SHALL load cnt+1 (1 if first=1), out_valid SHALL set, and first SHALL set.
REQ-023 Latency SHALL be one cycle: out_valid rises on the edge that accepts the last beat.
REQ-024 A single beat with in_last=1 and first=1 SHALL produce out = in and out_nbeats = 1.
REQ-025 On an output handshake with no simultaneous last-beat acceptance, out_valid SHALL clear; out and out_nbeats SHALL hold their values.
REQ-026 On an output handshake in the same cycle as a last-beat acceptance, res SHALL load the new tile and out_valid SHALL remain 1.
REQ-027 While out_valid=1 and out_ready=0, in_ready SHALL be 0 and acc, cnt, res and first SHALL hold.
REQ-028 out and out_nbeats SHALL be stable while out_valid=1 and no output handshake occurs.
REQ-029 in, in_last, in_valid=0 beats SHALL have no effect on state.
REQ-030 State interpretation: IDLE (first=1, out_valid=0), ACC (first=0), FULL (out_valid=1); transitions only via REQ-020 to REQ-027.

Reset
REQ-031 rst=0 SHALL asynchronously clear acc, res, cnt, out_nbeats and out_valid to 0 and set first to 1.
REQ-032 Reset mid-tile SHALL discard the partial accumulation and the held result; the first accepted beat after release starts a new tile.
REQ-033 Release of rst SHALL be sampled on clk; no beat is accepted on the edge where rst is still low.

Structure
REQ-034 Default parameter values and the lane-slice index function SHALL be shared with the tensor-core sources in the common package.
REQ-035 One sub-module, tc_acc_lane (single-lane adder plus accumulator register), SHALL be instantiated N_ADT*N_STACK times; control logic (first, cnt, out_valid, in_ready) SHALL sit in tc_acc.

Verification
REQ-036 Single beat, all lanes=5, in_last=1 -> next cycle out_valid=1, all lanes of out=5, out_nbeats=1.
REQ-037 Beats with lanes 1, 2, 3 (last on the 3rd), out_ready=1 -> out lanes=6, out_nbeats=3, out_valid high for exactly one cycle.
REQ-038 Lane 0 beats 0x7FFFFFFF then 0x00000001 (last) -> lane 0 of out = 0x80000000 (wrap); all other lanes unaffected.
REQ-039 out_ready=0 for 5 cycles after a tile completes -> in_ready=0 during the stall, out stable, no beats lost; on out_ready=1 a simultaneous last beat loads the new tile and out_valid stays 1.
REQ-040 rst pulsed low after 2 of 4 beats -> out_valid=0; a subsequent 1-beat tile with lanes=9 yields out=9, out_nbeats=1.
REQ-041 Distinct value per lane (value = r*16+s), 2 beats -> each lane of out = 2*(r*16+s), confirming the lane layout and no cross-lane leakage.
